// File: rtl/framed_shift_register.sv
// Frame-aware serial/parallel shift register used at the bottom of the SPI
// peripheral datapath. Receives on sampleEdge, transmits on shiftEdge, counts
// bits within a frame and holds the last completed received word.
module framed_shift_register #(
    parameter int width      = 8,
    parameter int countWidth = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  sampleEdge,
    input  logic                  shiftEdge,
    input  logic                  frameEnable,
    input  logic                  lsbFirst,
    input  logic                  parallelLoad,
    input  logic [width-1:0]      parallelDataIn,
    input  logic                  serialDataIn,
    output logic [width-1:0]      parallelDataOut,
    output logic                  serialDataOut,
    output logic [width-1:0]      rxData,
    output logic                  frameDone,
    output logic [countWidth-1:0] bitCount
);

    localparam logic [countWidth-1:0] lastBit = countWidth'(width - 1);

    logic             orderLsb;
    logic [width-1:0] mem;
    logic [width-1:0] memShifted;
    logic             sampleActive;
    logic             shiftActive;
    logic             wordComplete;

    // Decide which peripheral edges act this cycle; a load masks both edges.
    always_comb begin
        sampleActive = 1'b0;
        shiftActive  = 1'b0;
        wordComplete = 1'b0;
        memShifted   = mem;
        sampleActive = sampleEdge && frameEnable && !parallelLoad;
        shiftActive  = shiftEdge && frameEnable && !parallelLoad;
        wordComplete = sampleActive && (bitCount == lastBit);
        if (orderLsb) begin
            memShifted = {serialDataIn, mem[width-1:1]};
        end else begin
            memShifted = {mem[width-2:0], serialDataIn};
        end
    end

    // Bit order follows lsbFirst between frames and on loads, frozen mid-frame.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            orderLsb <= 1'b0;
        end else if (parallelLoad || !frameEnable) begin
            orderLsb <= lsbFirst;
        end
    end

    // Shift register contents: a parallel load wins over a sampled bit.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            mem <= '0;
        end else if (parallelLoad) begin
            mem <= parallelDataIn;
        end else if (sampleActive) begin
            mem <= memShifted;
        end
    end

    // Transmit bit: preloaded from the new word on a load, else launched from pre-shift mem.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            serialDataOut <= 1'b0;
        end else if (parallelLoad) begin
            serialDataOut <= lsbFirst ? parallelDataIn[0] : parallelDataIn[width-1];
        end else if (shiftActive) begin
            serialDataOut <= orderLsb ? mem[0] : mem[width-1];
        end
    end

    // Frame bit counter: cleared by loads and by chip select dropping, wraps on the last bit.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            bitCount <= '0;
        end else if (parallelLoad || !frameEnable) begin
            bitCount <= '0;
        end else if (sampleActive) begin
            bitCount <= wordComplete ? '0 : bitCount + countWidth'(1);
        end
    end

    // Capture the completed word and raise a single-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            rxData    <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= wordComplete;
            if (wordComplete) begin
                rxData <= memShifted;
            end
        end
    end

    assign parallelDataOut = mem;

endmodule

// File: tb/tb_framed_shift_register.sv
// Randomised scoreboard bench for framed_shift_register: the driver feeds a
// word-level reference model and queues the expected outputs, the monitor pops
// and compares them after every clock edge.
module tb_framed_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          resetN;
    logic          sampleEdge;
    logic          shiftEdge;
    logic          frameEnable;
    logic          lsbFirst;
    logic          parallelLoad;
    logic [W-1:0]  parallelDataIn;
    logic          serialDataIn;
    logic [W-1:0]  parallelDataOut;
    logic          serialDataOut;
    logic [W-1:0]  rxData;
    logic          frameDone;
    logic [CW-1:0] bitCount;

    typedef struct packed {
        logic [W-1:0]  pdo;
        logic          sdo;
        logic [W-1:0]  rx;
        logic          done;
        logic [CW-1:0] cnt;
    } snapT;

    snapT expQ[$];

    int  total = 0;
    int  bad   = 0;
    bit  driverDone = 0;

    // Reference model state (word level, plain arithmetic)
    int  mWord;
    int  mRx;
    int  mCnt;
    bit  mSdo;
    bit  mDone;
    bit  mLsb;

    framed_shift_register #(.width(W), .countWidth(CW)) dut (
        .clk(clk),
        .resetN(resetN),
        .sampleEdge(sampleEdge),
        .shiftEdge(shiftEdge),
        .frameEnable(frameEnable),
        .lsbFirst(lsbFirst),
        .parallelLoad(parallelLoad),
        .parallelDataIn(parallelDataIn),
        .serialDataIn(serialDataIn),
        .parallelDataOut(parallelDataOut),
        .serialDataOut(serialDataOut),
        .rxData(rxData),
        .frameDone(frameDone),
        .bitCount(bitCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, queue the expectation.
    task automatic applyStimulus(input bit rst, input bit smp, input bit shf, input bit fe,
                                 input bit lsb, input bit pl, input logic [W-1:0] pdi, input bit sdi);
        bit   nextLsb;
        int   oldWord;
        snapT s;
        @(negedge clk);
        resetN         = ~rst;
        sampleEdge     = smp;
        shiftEdge      = shf;
        frameEnable    = fe;
        lsbFirst       = lsb;
        parallelLoad   = pl;
        parallelDataIn = pdi;
        serialDataIn   = sdi;
        if (rst) begin
            mWord = 0; mRx = 0; mCnt = 0; mSdo = 0; mDone = 0; mLsb = 0;
        end else begin
            nextLsb = (pl || !fe) ? lsb : mLsb;
            mDone   = 0;
            if (pl) begin
                mWord = int'(pdi);
                mCnt  = 0;
                mSdo  = lsb ? (mWord % 2 == 1) : (mWord / (1 << (W-1)) == 1);
            end else if (!fe) begin
                mCnt = 0;
            end else begin
                oldWord = mWord;
                if (shf)
                    mSdo = mLsb ? (oldWord % 2 == 1) : (oldWord / (1 << (W-1)) == 1);
                if (smp) begin
                    if (mLsb) mWord = oldWord / 2 + int'(sdi) * (1 << (W-1));
                    else      mWord = (oldWord * 2 + int'(sdi)) % (1 << W);
                    mCnt++;
                    if (mCnt == W) begin
                        mCnt  = 0;
                        mRx   = mWord;
                        mDone = 1;
                    end
                end
            end
            mLsb = nextLsb;
        end
        s.pdo  = W'(mWord);
        s.sdo  = mSdo;
        s.rx   = W'(mRx);
        s.done = mDone;
        s.cnt  = CW'(mCnt);
        expQ.push_back(s);
    endtask

    // A sample edge followed by a quiet cycle, keeping sample edges two cycles apart.
    task automatic sampleBit(input bit fe, input bit lsb, input bit sdi, input bit shf);
        applyStimulus(0, 1, shf, fe, lsb, 0, '0, sdi);
        applyStimulus(0, 0, 0, fe, lsb, 0, '0, 0);
    endtask

    task automatic receiveWord(input logic [W-1:0] word, input bit lsbWire, input bit lsbReq);
        logic [W-1:0] w;
        w = word;
        for (int i = 0; i < W; i++) begin
            sampleBit(1, (i == 3) ? ~lsbReq : lsbReq, lsbWire ? w[i] : w[W-1-i], 0);
        end
    endtask

    // Pop and compare one expectation a little after each rising edge.
    initial begin : monitor
        snapT e;
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("parallelDataOut", parallelDataOut, e.pdo);
                checkOutput("serialDataOut", W'(serialDataOut), W'(e.sdo));
                checkOutput("rxData", rxData, e.rx);
                checkOutput("frameDone", W'(frameDone), W'(e.done));
                checkOutput("bitCount", W'(bitCount), W'(e.cnt));
            end
        end
    end

    initial begin : driver
        int waitCycles;
        resetN = 0; sampleEdge = 0; shiftEdge = 0; frameEnable = 0;
        lsbFirst = 0; parallelLoad = 0; parallelDataIn = '0; serialDataIn = 0;

        // Reset with edges and loads toggling, then idle out of frame
        for (int i = 0; i < 3; i++)
            applyStimulus(1, i[0], ~i[0], 1, 1, 1, 8'hFF, 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 8'h55, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 0);

        // MSB-first reception of 0xA5
        applyStimulus(0, 0, 0, 1, 0, 0, '0, 0);
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] a5;
            a5 = 8'hA5;
            sampleBit(1, 0, a5[W-1-i], 0);
        end

        // LSB-first load of 0x3C followed by alternating sample and shift edges
        applyStimulus(0, 0, 0, 1, 1, 1, 8'h3C, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 1, 0, 1, 1, 0, '0, 1'($urandom_range(0, 1)));
            applyStimulus(0, 0, 1, 1, 1, 0, '0, 0);
        end

        // Abort after 5 bits, then receive 0x0F MSB first
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) sampleBit(1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, '0, 1);
        for (int i = 0; i < W; i++) sampleBit(1, 0, (i >= 4), 0);

        // Load colliding with a sample edge, then sample and shift together on 0x80
        applyStimulus(0, 1, 1, 1, 0, 1, 8'h81, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 8'h80, 0);
        applyStimulus(0, 1, 1, 1, 0, 0, '0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 0);

        // lsbFirst toggling mid-frame while receiving 0xC3 MSB first
        applyStimulus(0, 0, 0, 1, 0, 0, '0, 0);
        receiveWord(8'hC3, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, '0, 0);
        receiveWord(8'h96, 1, 1);

        // Reset asserted mid-frame
        for (int i = 0; i < 3; i++) sampleBit(1, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 0, 0, '0, 1);
        for (int i = 0; i < W; i++) sampleBit(1, 0, 1'(i), 1);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            bit fe, lsb, pl, shf;
            fe  = ($urandom_range(0, 19) != 0);
            lsb = 1'($urandom_range(0, 1));
            pl  = ($urandom_range(0, 24) == 0);
            shf = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0)
                applyStimulus(1, 0, 0, fe, lsb, 0, '0, 0);
            else if (pl)
                applyStimulus(0, 1'($urandom_range(0, 1)), shf, fe, lsb, 1, W'($urandom), 1'($urandom_range(0, 1)));
            else
                sampleBit(fe, lsb, 1'($urandom_range(0, 1)), shf);
        end

        driverDone = 1;
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #5;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/framed_shift_register.md
Name: framed_shift_register

Overview:
Parametrised, frame-aware successor to the basic serial/parallel shift register, used at the bottom of the SPI peripheral datapath.
- Selectable MSB-first or LSB-first bit order.
- Separate sample and launch edge indicators, so received data and transmitted data are handled on opposite peripheral clock edges.
- Frame bit counter, frame-complete pulse and a holding register for the last completed received word.

Parameters:
width, 8, shift register and word width in bits; must be >= 2
countWidth, 4, bitCount width; must satisfy 2^countWidth > width

Ports:
clk  in  1  FPGA clock; all state updates on its rising edge
resetN  in  1  synchronous active-low reset
sampleEdge  in  1  one-cycle pulse marking a peripheral sampling edge
shiftEdge  in  1  one-cycle pulse marking a peripheral launch edge
frameEnable  in  1  1 = frame active (chip select asserted)
lsbFirst  in  1  requested bit order: 1 = LSB first, 0 = MSB first
parallelLoad  in  1  1 = load mem from parallelDataIn
parallelDataIn  in  width  transmit word
serialDataIn  in  1  receive serial bit
parallelDataOut  out  width  live contents of mem
serialDataOut  out  1  registered transmit bit
rxData  out  width  last completed received word
frameDone  out  1  one-cycle pulse when a full word has been received
bitCount  out  countWidth  bits received in the current frame

Behaviour:
Reset (resetN low at a clk edge; overrides everything):
- mem = 0, serialDataOut = 0, rxData = 0, frameDone = 0, bitCount = 0, internal order register = 0 (MSB first).

Bit order register:
- Loads lsbFirst on any cycle where parallelLoad = 1 or frameEnable = 0.
- Otherwise holds; changes to lsbFirst during an active frame are ignored.

Action priority per cycle (the priority among same-cycle events is deliberate):
1. parallelLoad = 1:
   - mem <= parallelDataIn; bitCount <= 0.
   - serialDataOut <= parallelDataIn[width-1] if the new order is MSB first, else parallelDataIn[0]. The new order is the lsbFirst value being loaded this cycle.
   - Any sampleEdge in the same cycle is dropped. shiftEdge in the same cycle has no effect.
2. sampleEdge = 1 and frameEnable = 1:
   - MSB first: mem <= {mem[width-2:0], serialDataIn}.
   - LSB first: mem <= {serialDataIn, mem[width-1:1]}.
   - bitCount increments.
   - If bitCount was width-1 before this edge: bitCount <= 0, rxData <= the new mem value, frameDone = 1 in the following cycle only.
3. shiftEdge = 1 and frameEnable = 1, without parallelLoad:
   - serialDataOut <= mem[width-1] (MSB first) or mem[0] (LSB first).
   - Uses the pre-update mem value, even when sampleEdge fires in the same cycle.

Frame abort:
- frameEnable = 0 at any clk edge sets bitCount <= 0.
- Edges are ignored while frameEnable = 0.
- mem, rxData and serialDataOut are held; no frameDone is generated.

Other rules:
- frameDone is exactly one cycle wide and never back-to-back, because sample edges are at least 2 clk cycles apart.
- bitCount never reaches width; it wraps to 0 on the completing edge.
- Reset asserted mid-frame clears the frame immediately; the first post-reset word requires a full width sample edges.
- Latency: rxData and frameDone are visible 1 cycle after the completing sampleEdge cycle. parallelDataOut reflects each shift 1 cycle after the edge.

Test Plan:
1. resetN low for 3 cycles with sampleEdge, shiftEdge and parallelLoad toggling -> all outputs 0. After release with frameEnable = 0 -> outputs unchanged.
2. width = 8, MSB first, frameEnable = 1, serialDataIn drives 0xA5 MSB first over 8 sampleEdges -> bitCount goes 1..7 then 0; frameDone high for exactly 1 cycle; rxData = 0xA5 = parallelDataOut.
3. lsbFirst = 1, load 0x3C -> serialDataOut = 0 immediately after the load. Then 7 alternating sample/shift edge pairs -> serialDataOut sequence 0,1,1,1,1,0,0.
4. Abort and recover: frameEnable drops after 5 sampleEdges -> bitCount = 0, no frameDone, rxData holds its prior value. A following full frame receiving 0x0F -> rxData = 0x0F.
5. Collisions:
   - parallelLoad of 0x81 in the same cycle as sampleEdge -> mem = 0x81, bitCount = 0.
   - sampleEdge with shiftEdge in the same cycle (MSB first, mem = 0x80) -> serialDataOut = 1, mem = {0x00 | serialDataIn}.
6. Toggle lsbFirst mid-frame while receiving 0xC3 MSB first -> received word is still 0xC3. After frameEnable drops, the new order takes effect.
